// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates NUM_SAMPLES 5-bit operands {c_out,sum} with ready/valid handshakes; define ACC_SAT_EN to saturate instead of wrap on overflow.
module sum_accumulator #(
    parameter int NUM_SAMPLES = 4,
    parameter int ACC_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             c_out,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic [3:0]       count
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NUM_SAMPLES);

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc_nx;
    logic             ovf_nx;
    logic [3:0]       cnt_nx;
    logic [ACC_W-1:0] operand;
    logic [ACC_W:0]   total;
    logic             accept;

    assign operand   = ACC_W'({c_out, sum});
    assign total     = {1'b0, acc_out} + {1'b0, operand};
    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready && !clear;

    // next-state and datapath: clear beats handshake, handshake beats nothing else in DONE, accepts load or add
    always_comb begin
        state_nx = state;
        acc_nx   = acc_out;
        ovf_nx   = overflow;
        cnt_nx   = count;
        if (clear || (state == DONE && out_ready)) begin
            state_nx = IDLE;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
            cnt_nx   = '0;
        end else if (accept) begin
            cnt_nx = state == IDLE ? 4'd1 : count + 4'd1;
            if (state == IDLE) begin
                acc_nx = operand;
                ovf_nx = 1'b0;
            end else begin
                ovf_nx = overflow | total[ACC_W];
`ifdef ACC_SAT_EN
                acc_nx = total[ACC_W] ? '1 : total[ACC_W-1:0];
`else
                acc_nx = total[ACC_W-1:0];
`endif
            end
            state_nx = cnt_nx == LAST ? DONE : ACCUM;
        end
    end

    // state and result registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_nx;
            acc_out  <= acc_nx;
            overflow <= ovf_nx;
            count    <= cnt_nx;
        end
    end
endmodule
